// File: rtl/tx_scheduler.sv
// tx_scheduler
// Shares one UART transmitter between the echo-data FIFO and the
// acknowledge-message generator ("OK\r\n" after finish, "CL\r\n" after clean),
// and owns the transmitter's baud-select register. A rate change only takes
// effect once the acknowledge that announces it has completely left the line.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   fifo_empty      echo FIFO empty
//   fifo_data       echo FIFO read data, valid the cycle after fifo_rd
//   fifo_rd         one-cycle FIFO read strobe
//   finish_pulse    rate-control sequence finished (rate_in sampled here)
//   clean_pulse     clean command
//   rate_in         rate code from the parser
//   tx_busy         transmitter is shifting a byte
//   tx_start        one-cycle start strobe to the transmitter
//   tx_data         byte to transmit, held from tx_start until tx_busy falls
//   baud_sel        applied baud code
//   baud_update     one-cycle pulse when baud_sel takes a new value
//   tx_err          sticky: transmitter never acknowledged a start
//   msg_overrun     sticky: finish/clean arrived while the same request pending
module tx_scheduler #(
   parameter logic [1:0]  RATE_DEFAULT  = 2'b00,
   parameter int unsigned START_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd,
   input  logic       finish_pulse,
   input  logic       clean_pulse,
   input  logic [1:0] rate_in,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic [1:0] baud_sel,
   output logic       baud_update,
   output logic       tx_err,
   output logic       msg_overrun
);

   localparam logic [15:0] TO_LAST = 16'(START_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FIFO_RD,
      S_FIFO_CAP,
      S_MSG_LOAD,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO,
      S_RATE_APPLY
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;          // byte index inside the acknowledge
   logic        msg_q, msg_d;          // current byte belongs to a message
   logic        sel_clr_q, sel_clr_d;  // 0: finish message, 1: clean message
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [1:0]  baud_q, baud_d;
   logic        err_q, err_d;
   logic        ovr_q, ovr_d;
   logic        fin_pend_q, fin_pend_d;
   logic        clr_pend_q, clr_pend_d;
   logic [1:0]  rate_lat_q, rate_lat_d;

   logic        fin_clr;               // served/aborted finish request retires
   logic        clr_clr;               // served/aborted clean request retires
   logic [1:0]  target;

   function automatic logic [7:0] msg_byte(input logic sel_clr, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = sel_clr ? 8'h43 : 8'h4F;
         2'd1:    b = sel_clr ? 8'h4C : 8'h4B;
         2'd2:    b = 8'h0D;
         default: b = 8'h0A;
      endcase
      return b;
   endfunction

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      msg_d       = msg_q;
      sel_clr_d   = sel_clr_q;
      cnt_d       = cnt_q;
      tx_data_d   = tx_data_q;
      baud_d      = baud_q;
      err_d       = err_q;
      ovr_d       = ovr_q;
      fin_pend_d  = fin_pend_q;
      clr_pend_d  = clr_pend_q;
      rate_lat_d  = rate_lat_q;
      fifo_rd     = 1'b0;
      tx_start    = 1'b0;
      baud_update = 1'b0;
      fin_clr     = 1'b0;
      clr_clr     = 1'b0;
      target      = baud_q;

      case (state_q)
         S_IDLE: begin
            // Acknowledges outrank echo data; finish outranks clean so that a
            // simultaneous pair applies the new rate before reverting it.
            if (!tx_busy) begin
               if (fin_pend_q) begin
                  msg_d     = 1'b1;
                  sel_clr_d = 1'b0;
                  idx_d     = 2'd0;
                  state_d   = S_MSG_LOAD;
               end else if (clr_pend_q) begin
                  msg_d     = 1'b1;
                  sel_clr_d = 1'b1;
                  idx_d     = 2'd0;
                  state_d   = S_MSG_LOAD;
               end else if (!fifo_empty) begin
                  msg_d   = 1'b0;
                  state_d = S_FIFO_RD;
               end
            end
         end
         S_FIFO_RD: begin
            fifo_rd = 1'b1;
            state_d = S_FIFO_CAP;
         end
         S_FIFO_CAP: begin
            tx_data_d = fifo_data;
            state_d   = S_START;
         end
         S_MSG_LOAD: begin
            tx_data_d = msg_byte(sel_clr_q, idx_q);
            state_d   = S_START;
         end
         S_START: begin
            tx_start = 1'b1;
            cnt_d    = 16'd0;
            state_d  = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (tx_busy) begin
               state_d = S_WAIT_LO;
            end else if (cnt_q == TO_LAST) begin
               // Transmitter never answered: drop the byte, and if it was part
               // of an acknowledge, drop the whole request without a rate change.
               err_d = 1'b1;
               if (msg_q) begin
                  if (sel_clr_q) clr_clr = 1'b1;
                  else           fin_clr = 1'b1;
               end
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_WAIT_LO: begin
            if (!tx_busy) begin
               if (!msg_q) begin
                  state_d = S_IDLE;
               end else if (idx_q != 2'd3) begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_MSG_LOAD;
               end else begin
                  state_d = S_RATE_APPLY;
               end
            end
         end
         S_RATE_APPLY: begin
            if (sel_clr_q) begin
               clr_clr    = 1'b1;
               target     = RATE_DEFAULT;
               rate_lat_d = RATE_DEFAULT;
            end else begin
               fin_clr = 1'b1;
               target  = rate_lat_q;
            end
            baud_d      = target;
            baud_update = (target != baud_q);
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (fin_clr) fin_pend_d = 1'b0;
      if (clr_clr) clr_pend_d = 1'b0;

      // A new pulse always wins over retirement of the same request, and is
      // only an overrun if the earlier request is still outstanding.
      if (finish_pulse) begin
         if (fin_pend_q && !fin_clr) ovr_d = 1'b1;
         fin_pend_d = 1'b1;
         rate_lat_d = rate_in;
      end
      if (clean_pulse) begin
         if (clr_pend_q && !clr_clr) ovr_d = 1'b1;
         clr_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= 2'd0;
         msg_q      <= 1'b0;
         sel_clr_q  <= 1'b0;
         cnt_q      <= 16'd0;
         tx_data_q  <= 8'h00;
         baud_q     <= RATE_DEFAULT;
         err_q      <= 1'b0;
         ovr_q      <= 1'b0;
         fin_pend_q <= 1'b0;
         clr_pend_q <= 1'b0;
         rate_lat_q <= RATE_DEFAULT;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         msg_q      <= msg_d;
         sel_clr_q  <= sel_clr_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         baud_q     <= baud_d;
         err_q      <= err_d;
         ovr_q      <= ovr_d;
         fin_pend_q <= fin_pend_d;
         clr_pend_q <= clr_pend_d;
         rate_lat_q <= rate_lat_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign baud_sel    = baud_q;
   assign tx_err      = err_q;
   assign msg_overrun = ovr_q;

endmodule

// File: tb/tb_tx_scheduler.sv
module tb_tx_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_rd;
   logic       finish_pulse;
   logic       clean_pulse;
   logic [1:0] rate_in;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [1:0] baud_sel;
   logic       baud_update;
   logic       tx_err;
   logic       msg_overrun;

   always #5 clk = ~clk;

   tx_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .fifo_empty   (fifo_empty),
      .fifo_data    (fifo_data),
      .fifo_rd      (fifo_rd),
      .finish_pulse (finish_pulse),
      .clean_pulse  (clean_pulse),
      .rate_in      (rate_in),
      .tx_busy      (tx_busy),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .baud_sel     (baud_sel),
      .baud_update  (baud_update),
      .tx_err       (tx_err),
      .msg_overrun  (msg_overrun)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0] fq[$];        // echo FIFO contents
   logic [7:0] expq[$];      // bytes expected on the line, in order
   logic [1:0] baudq[$];     // baud values expected after each baud_update
   logic [1:0] cur_baud = 2'b00;
   bit         err_exp = 0;
   bit         ovr_exp = 0;
   int         rd_cnt = 0;
   int         push_cnt = 0;

   // Transmitter model controls
   bit         stuck = 0;
   bit         tx_active = 0;
   bit         chk_on = 1;
   int         dly_cfg = 0;
   int         len_cfg = 0;
   int         txm_dly, txm_len;
   logic [7:0] txm_held;

   // Monitor state
   logic [7:0] last_byte = 8'h00;
   bit         pend_b = 0;
   logic [1:0] bexp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input int act, input int exp);
      checks++;
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Transmitter: busy rises dly cycles after the start strobe, lasts len cycles
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start && !stuck) begin
            txm_held  = tx_data;
            tx_active = 1;
            txm_dly   = (dly_cfg != 0) ? dly_cfg : int'($urandom_range(4, 1));
            txm_len   = (len_cfg != 0) ? len_cfg : int'($urandom_range(12, 1));
            repeat (txm_dly) @(negedge clk);
            tx_busy = 1'b1;
            repeat (txm_len) @(negedge clk);
            tx_busy   = 1'b0;
            tx_active = 0;
            if (chk_on) chk("tx_data_held", tx_data, txm_held);
         end
      end
   end

   // Echo FIFO: data appears after the read strobe
   initial begin
      fifo_data = 8'h00;
      forever begin
         @(negedge clk);
         if (fifo_rd) begin
            rd_cnt++;
            if (fq.size() == 0) fail_now("fifo_rd_on_empty", 0, 1);
            else fifo_data = fq.pop_front();
            fifo_empty = (fq.size() == 0);
         end
      end
   end

   // Scoreboard monitor
   initial begin
      forever begin
         @(negedge clk);
         if (pend_b) begin
            chk("baud_sel_after_update", baud_sel, bexp);
            pend_b = 0;
         end
         if (tx_start) begin
            chk("start_while_busy", tx_busy, 0);
            if (expq.size() == 0) fail_now("unexpected_tx_start", 1, 0);
            else chk("tx_data", tx_data, expq.pop_front());
            last_byte = tx_data;
         end
         if (baud_update) begin
            chk("baud_after_last_byte", {last_byte, tx_active}, {8'h0A, 1'b0});
            if (baudq.size() == 0) fail_now("unexpected_baud_update", 1, 0);
            else begin
               bexp   = baudq.pop_front();
               pend_b = 1;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic push_fifo(input logic [7:0] b);
      fq.push_back(b);
      expq.push_back(b);
      fifo_empty = 1'b0;
      push_cnt++;
   endtask

   task automatic push_msg(input bit clr);
      if (clr) begin
         expq.push_back(8'h43); expq.push_back(8'h4C);
      end else begin
         expq.push_back(8'h4F); expq.push_back(8'h4B);
      end
      expq.push_back(8'h0D);
      expq.push_back(8'h0A);
   endtask

   task automatic exp_rate(input logic [1:0] r);
      if (r != cur_baud) begin
         baudq.push_back(r);
         cur_baud = r;
      end
   endtask

   task automatic pulse(input bit fin, input bit clr, input logic [1:0] r);
      rate_in      = r;
      finish_pulse = fin;
      clean_pulse  = clr;
      @(negedge clk);
      finish_pulse = 1'b0;
      clean_pulse  = 1'b0;
   endtask

   task automatic cycles_to_start(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!tx_start && k < 64);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((expq.size() != 0 || tx_active) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      if (n >= 3000) fail_now("idle_timeout", n, 3000);
      repeat (6) @(negedge clk);
      chk("baud_sel", baud_sel, cur_baud);
      chk("baud_updates_outstanding", baudq.size(), 0);
      chk("tx_err", tx_err, err_exp);
      chk("msg_overrun", msg_overrun, ovr_exp);
      chk("fifo_rd_count", rd_cnt, push_cnt);
   endtask

   initial begin
      int k;
      int t;
      logic [1:0] r1, r2;
      reset        = 1'b1;
      fifo_empty   = 1'b1;
      finish_pulse = 1'b0;
      clean_pulse  = 1'b0;
      rate_in      = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_fifo_rd", fifo_rd, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_baud_sel", baud_sel, 2'b00);
      chk("rst_baud_update", baud_update, 0);
      chk("rst_tx_err", tx_err, 0);
      chk("rst_msg_overrun", msg_overrun, 0);
      reset = 1'b0;
      @(negedge clk);

      // Two echo bytes, transmitter busy 2 cycles after start for 10 cycles
      dly_cfg = 2; len_cfg = 10;
      push_fifo(8'h41);
      push_fifo(8'h42);
      cycles_to_start(k);
      chk("fifo_latency", k, 3);
      wait_idle();

      // Finish with rate 3: one cycle to latch the request, then two to start
      push_msg(0);
      exp_rate(2'b11);
      pulse(1, 0, 2'b11);
      cycles_to_start(k);
      chk("msg_latency", k, 2);
      wait_idle();
      dly_cfg = 0; len_cfg = 0;

      // Finish (rate 1) and clean together
      push_msg(0); exp_rate(2'b01);
      push_msg(1); exp_rate(2'b00);
      pulse(1, 1, 2'b01);
      wait_idle();

      // Echo data waiting behind a pending finish
      r1 = 2'($urandom_range(3, 0));
      push_msg(0); exp_rate(r1);
      pulse(1, 0, r1);
      push_fifo(8'($urandom));
      push_fifo(8'($urandom));
      wait_idle();

      // Second finish while the first is still pending
      r1 = 2'($urandom_range(3, 0));
      r2 = r1 + 2'd1 + 2'($urandom_range(2, 0));
      push_msg(0);
      pulse(1, 0, r1);
      repeat (3) @(negedge clk);
      pulse(1, 0, r2);
      exp_rate(r2);
      ovr_exp = 1;
      wait_idle();

      // Transmitter never answers the start strobe
      stuck = 1;
      push_fifo(8'h5A);
      cycles_to_start(k);
      repeat (16) @(negedge clk);
      chk("tx_err_before_timeout", tx_err, 0);
      @(negedge clk);
      chk("tx_err_at_timeout", tx_err, 1);
      err_exp = 1;
      stuck = 0;
      push_fifo(8'hA5);
      wait_idle();

      // Randomised mix of traffic
      for (int i = 0; i < 20; i++) begin
         t  = int'($urandom_range(4, 0));
         r1 = 2'($urandom_range(3, 0));
         case (t)
            0: begin
               k = int'($urandom_range(4, 1));
               for (int j = 0; j < k; j++) push_fifo(8'($urandom));
            end
            1: begin push_msg(0); exp_rate(r1); pulse(1, 0, r1); end
            2: begin push_msg(1); exp_rate(2'b00); pulse(0, 1, r1); end
            3: begin
               push_msg(0); exp_rate(r1);
               push_msg(1); exp_rate(2'b00);
               pulse(1, 1, r1);
            end
            default: begin
               push_msg(0); exp_rate(r1);
               pulse(1, 0, r1);
               k = int'($urandom_range(3, 1));
               for (int j = 0; j < k; j++) push_fifo(8'($urandom));
            end
         endcase
         wait_idle();
      end

      // Reset in the middle of an acknowledge: request and rate are lost
      chk_on = 0;
      push_msg(0);
      pulse(1, 0, 2'b10);
      cycles_to_start(k);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      expq.delete();
      chk("midrst_tx_data", tx_data, 8'h00);
      chk("midrst_baud_sel", baud_sel, 2'b00);
      chk("midrst_tx_err", tx_err, 0);
      chk("midrst_msg_overrun", msg_overrun, 0);
      repeat (60) @(negedge clk);
      chk("midrst_baud_sel_later", baud_sel, 2'b00);
      chk("midrst_baud_updates", baudq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_scheduler.md
Name: tx_scheduler

Overview:
- Sequences the single shared UART transmitter between two requesters.
- Requester 1 is the echo-data FIFO, filled by the command parser's normal-data writes.
- Requester 2 is the acknowledge-message generator, triggered by the parser's finish and clean pulses.
- Owns the transmitter's baud-select register: a rate change is applied only at a byte boundary, after the matching acknowledge has fully left the line.

Parameters:
- RATE_DEFAULT, 2'b00, baud_sel value after reset and after a clean command.
- START_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before aborting the byte.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- fifo_empty  input  1  echo FIFO empty
- fifo_data  input  8  echo FIFO read data; valid one cycle after fifo_rd
- fifo_rd  output  1  one-cycle FIFO read strobe
- finish_pulse  input  1  one-cycle pulse: rate-control sequence finished
- clean_pulse  input  1  one-cycle pulse: clean command
- rate_in  input  2  rate code from parser; sampled on finish_pulse
- tx_busy  input  1  transmitter shifting a byte
- tx_start  output  1  one-cycle start strobe to transmitter
- tx_data  output  8  byte to transmit; held stable from tx_start until tx_busy falls
- baud_sel  output  2  applied baud code
- baud_update  output  1  one-cycle pulse when baud_sel changes value
- tx_err  output  1  sticky: start timeout occurred
- msg_overrun  output  1  sticky: finish/clean pulse arrived while same request already pending

Behaviour:
- Reset (sync, high): state IDLE; all pulses 0; tx_data 8'h00; baud_sel RATE_DEFAULT; tx_err 0; msg_overrun 0; pending flags 0; rate latch RATE_DEFAULT.
- Pending flags (every cycle, any state):
  - finish_pulse sets fin_pend and latches rate_in into rate_lat.
  - clean_pulse sets clr_pend.
  - A pulse arriving while its flag is already set sets msg_overrun. For a finish overrun, rate_lat still updates to the newest rate_in.
- States: IDLE, FIFO_RD, FIFO_CAP, MSG_LOAD, START, WAIT_HI, WAIT_LO, RATE_APPLY.
- IDLE arbitration, evaluated only when tx_busy=0:
  - Priority: fin_pend, then clr_pend, then FIFO.
  - fin_pend: select message "OK\r\n" (4F 4B 0D 0A) -> MSG_LOAD.
  - Else clr_pend: select message "CL\r\n" (43 4C 0D 0A) -> MSG_LOAD.
  - Else !fifo_empty -> FIFO_RD.
  - Otherwise stay in IDLE.
- FIFO_RD: fifo_rd=1 for one cycle -> FIFO_CAP.
- FIFO_CAP: tx_data <= fifo_data -> START.
- MSG_LOAD: tx_data <= message[idx], 2-bit idx starting at 0 -> START.
  - The message runs to completion; no FIFO byte interleaves.
  - New pending flags are not served until it finishes.
- START: tx_start=1 for one cycle; clear 16-bit timeout counter -> WAIT_HI.
- WAIT_HI:
  - tx_busy=1 -> WAIT_LO.
  - Counter reaches START_TIMEOUT-1 with tx_busy still 0: set tx_err, abandon the current byte (FIFO byte lost; message aborted, its pending flag cleared, no rate applied) -> IDLE.
- WAIT_LO: on tx_busy=0:
  - FIFO byte -> IDLE.
  - Message with idx<3: idx+1 -> MSG_LOAD.
  - Message with idx=3 -> RATE_APPLY.
- RATE_APPLY: clear the served pending flag (fin or clr).
  - Target: rate_lat for finish; RATE_DEFAULT for clean (rate_lat also reset to RATE_DEFAULT).
  - Update baud_sel to the target.
  - baud_update=1 for that cycle only if the value differs.
  - -> IDLE.
- Simultaneous finish_pulse and clean_pulse: both latched. Finish message plus its rate apply first, then clean message and RATE_DEFAULT.
- A pulse arriving on the cycle RATE_APPLY clears the same flag: the flag stays set (set wins), no overrun.
- Latency: IDLE with FIFO non-empty to tx_start is 3 cycles; IDLE with a pending message to tx_start is 2 cycles.
- Reset mid-byte: immediate return to IDLE. Pending messages are lost; baud_sel returns to RATE_DEFAULT.

Test Plan:
- FIFO holds 41,42; tx model raises busy 2 cycles after start for 10 cycles -> tx_data 41 then 42, one fifo_rd each, no tx_start while busy.
- finish_pulse with rate_in=2'b11 -> bytes 4F 4B 0D 0A sent; afterwards baud_sel=11, single baud_update pulse, never before 0A completes.
- finish (rate 01) and clean on same cycle -> "OK\r\n" then "CL\r\n"; baud_sel 01 then 00, two baud_update pulses.
- FIFO non-empty while finish pending -> all 4 message bytes before any fifo_rd.
- tx_busy held 0 after tx_start -> tx_err=1 after 16 cycles; return to IDLE; next FIFO byte still served.
- Second finish_pulse while fin_pend set -> msg_overrun=1; one message sent; baud_sel = second rate_in.
